// File: rtl/pll_lock_supervisor_if.sv
// Lock input and reset/status outputs of the PLL lock supervisor.
// master = supervisor side, slave = PLL/display side.
interface pll_lock_supervisor_if #(
    parameter int MAX_RETRIES = 4
);
    localparam int ATTEMPT_W = $clog2(MAX_RETRIES + 1);

    logic                 lock;
    logic                 pll_reset;
    logic                 sys_rst;
    logic                 ready;
    logic                 fault;
    logic [ATTEMPT_W-1:0] attempt;
    logic [7:0]           loss_cnt;

    modport master (
        input  lock,
        output pll_reset, sys_rst, ready, fault, attempt, loss_cnt
    );

    modport slave (
        output lock,
        input  pll_reset, sys_rst, ready, fault, attempt, loss_cnt
    );
endinterface

// File: rtl/pll_lock_supervisor.sv
// Pixel-clock rPLL supervisor: reset pulse, lock wait with bounded retries, lock-stable
// qualification and lock-loss restart. `PLL_SUP_LOSS_COUNT_EN builds the lock-loss counter.
module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 4
) (
    input logic                   clkin,
    input logic                   reset,
    pll_lock_supervisor_if.master bus
);
    localparam int MAX_RS  = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
    localparam int CNT_MAX = (LOCK_TIMEOUT > MAX_RS) ? LOCK_TIMEOUT : MAX_RS;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int AW      = $clog2(MAX_RETRIES + 1);

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_END  = CW'(STABLE_CYCLES);
    localparam logic [AW-1:0] ATTEMPT_MAX = AW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PRST,
        S_WAIT,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] attempt_q, attempt_d;
    logic [AW-1:0] attempt_inc;
    logic [1:0]    sync_q, sync_d;
    logic          lock_s;
    logic          pll_reset_q, pll_reset_d;
    logic          sys_rst_q, sys_rst_d;
    logic          ready_q, ready_d;
    logic          fault_q, fault_d;

    assign sync_d      = {sync_q[0], bus.lock};
    assign lock_s      = sync_q[1];
    assign attempt_inc = attempt_q + AW'(1);

    always_comb begin
        // NOTE: every _d is given its default first so no path through the case can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        attempt_d = attempt_q;

        case (state_q)
            S_PRST: begin
                // After a lock loss the first PRST cycle has pll_reset low; counting starts once it is high.
                if (pll_reset_q) begin
                    if (cnt_q == RST_LAST) begin
                        state_d = S_WAIT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_WAIT: begin
                if (lock_s) begin
                    state_d = S_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TO_LAST) begin
                    cnt_d     = '0;
                    attempt_d = attempt_inc;
                    state_d   = (attempt_inc == ATTEMPT_MAX) ? S_FAULT : S_PRST;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STABLE: begin
                if (!lock_s) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_END) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    state_d = S_PRST;
                    cnt_d   = '0;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_PRST;
                cnt_d   = '0;
            end
        endcase

        if (state_d == S_RUN) begin
            attempt_d = '0;
        end

        // Display reset asserts one cycle before the PLL is pulsed on a lock loss.
        pll_reset_d = (state_d == S_FAULT) || ((state_d == S_PRST) && (state_q != S_RUN));
        sys_rst_d   = (state_d != S_RUN);
        ready_d     = (state_d == S_RUN);
        fault_d     = (state_d == S_FAULT);
    end

    always_ff @(posedge clkin) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
        if (reset) begin
            state_q     <= S_PRST;
            cnt_q       <= '0;
            attempt_q   <= '0;
            sync_q      <= '0;
            pll_reset_q <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            attempt_q   <= attempt_d;
            sync_q      <= sync_d;
            pll_reset_q <= pll_reset_d;
            sys_rst_q   <= sys_rst_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    assign bus.pll_reset = pll_reset_q;
    assign bus.sys_rst   = sys_rst_q;
    assign bus.ready     = ready_q;
    assign bus.fault     = fault_q;
    assign bus.attempt   = attempt_q;

`ifdef PLL_SUP_LOSS_COUNT_EN
    logic [7:0] loss_cnt_q, loss_cnt_d;

    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if ((state_q == S_RUN) && !lock_s && (loss_cnt_q != 8'hFF)) begin
            loss_cnt_d = loss_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            loss_cnt_q <= 8'd0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign bus.loss_cnt = loss_cnt_q;
`else
    assign bus.loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor (RST=4, TIMEOUT=32, STABLE=8, RETRIES=2).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_pll_lock_supervisor;
    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 32;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;

`ifdef PLL_SUP_LOSS_COUNT_EN
    localparam int LOSS_STEP = 1;
`else
    localparam int LOSS_STEP = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    pll_lock_supervisor_if #(.MAX_RETRIES(MAX_RETRIES)) bus ();

    pll_lock_supervisor #(
        .RST_CYCLES   (RST_CYCLES),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .STABLE_CYCLES(STABLE_CYCLES),
        .MAX_RETRIES  (MAX_RETRIES)
    ) dut (
        .clkin(clk),
        .reset(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic pr, input logic sr, input logic rdy,
                              input logic flt, input logic [31:0] att, input logic [31:0] loss);
        check({tag, ".pll_reset"}, 32'(bus.pll_reset), 32'(pr));
        check({tag, ".sys_rst"},   32'(bus.sys_rst),   32'(sr));
        check({tag, ".ready"},     32'(bus.ready),     32'(rdy));
        check({tag, ".fault"},     32'(bus.fault),     32'(flt));
        check({tag, ".attempt"},   32'(bus.attempt),   att);
        check({tag, ".loss_cnt"},  32'(bus.loss_cnt),  loss);
    endtask

    initial begin
        // Scenario 1: clean start, lock 10 cycles after pll_reset falls.
        bus.lock = 1'b0;
        rst      = 1'b1;
        step(3);
        rst = 1'b0;
        check_outs("s1_reset", 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < RST_CYCLES; i++) begin
            check("s1_prst_high", 32'(bus.pll_reset), 32'd1);
            step(1);
        end
        check("s1_prst_fall", 32'(bus.pll_reset), 32'd0);
        step(10);
        bus.lock = 1'b1;
        step(11);
        check("s1_ready_early", 32'(bus.ready), 32'd0);
        check("s1_sysrst_early", 32'(bus.sys_rst), 32'd1);
        step(1);
        check_outs("s1_run", 0, 0, 1, 0, 0, 0);

        // Scenario 4: one-cycle lock drop in RUN.
        bus.lock = 1'b0;
        step(1);
        bus.lock = 1'b1;
        step(1);
        check("s4_ready_hold", 32'(bus.ready), 32'd1);
        step(1);
        check_outs("s4_loss", 0, 1, 0, 0, 0, 32'(LOSS_STEP));
        for (int i = 0; i < RST_CYCLES; i++) begin
            step(1);
            check("s4_prst_high", 32'(bus.pll_reset), 32'd1);
        end
        step(1);
        check("s4_prst_fall", 32'(bus.pll_reset), 32'd0);
        step(9);
        check("s4_ready_early", 32'(bus.ready), 32'd0);
        step(1);
        check_outs("s4_relock", 0, 0, 1, 0, 0, 32'(LOSS_STEP));

        // Scenario 6: second loss, then a 1-cycle reset midway through STABLE.
        bus.lock = 1'b0;
        step(1);
        bus.lock = 1'b1;
        step(11);
        check("s6_loss2", 32'(bus.loss_cnt), 32'(2 * LOSS_STEP));
        check("s6_in_stable", 32'(bus.ready), 32'd0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_outs("s6_reset", 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < RST_CYCLES; i++) begin
            check("s6_prst_high", 32'(bus.pll_reset), 32'd1);
            step(1);
        end
        check("s6_prst_fall", 32'(bus.pll_reset), 32'd0);
        step(9);
        check("s6_ready_early", 32'(bus.ready), 32'd0);
        step(1);
        check_outs("s6_run", 0, 0, 1, 0, 0, 0);

        // Scenario 3: 5-cycle lock glitch aborts STABLE, then steady lock.
        bus.lock = 1'b0;
        rst      = 1'b1;
        step(3);
        rst = 1'b0;
        step(4);
        check("s3_wait", 32'(bus.pll_reset), 32'd0);
        step(2);
        bus.lock = 1'b1;
        step(5);
        bus.lock = 1'b0;
        step(1);
        bus.lock = 1'b1;
        step(2);
        check_outs("s3_abort", 0, 1, 0, 0, 0, 0);
        step(9);
        check("s3_ready_early", 32'(bus.ready), 32'd0);
        step(1);
        check_outs("s3_run", 0, 0, 1, 0, 0, 0);

        // Scenario 5: lock_s arrives on the timeout cycle.
        bus.lock = 1'b0;
        rst      = 1'b1;
        step(3);
        rst = 1'b0;
        step(4 + 29);
        bus.lock = 1'b1;
        check("s5_attempt_pre", 32'(bus.attempt), 32'd0);
        step(3);
        check_outs("s5_lock_wins", 0, 1, 0, 0, 0, 0);
        step(9);
        check("s5_run", 32'(bus.ready), 32'd1);

        // Scenario 2: no lock, two timeouts, then FAULT until reset.
        bus.lock = 1'b0;
        rst      = 1'b1;
        step(3);
        rst = 1'b0;
        step(4 + 31);
        check_outs("s2_wait1_end", 0, 1, 0, 0, 0, 0);
        step(1);
        check_outs("s2_retry1", 1, 1, 0, 0, 1, 0);
        step(3);
        check("s2_retry1_prst", 32'(bus.pll_reset), 32'd1);
        step(1);
        check("s2_wait2", 32'(bus.pll_reset), 32'd0);
        step(31);
        check_outs("s2_wait2_end", 0, 1, 0, 0, 1, 0);
        step(1);
        check_outs("s2_fault", 1, 1, 0, 1, 2, 0);
        bus.lock = 1'b1;
        step(20);
        check_outs("s2_fault_sticky", 1, 1, 0, 1, 2, 0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_outs("s2_cleared", 1, 1, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
